// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Multi-cycle multiply/divide unit with HI/LO registers for the EX
//            stage; fixed-latency mult/multu/div/divu plus mthi/mtlo.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_sel,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDO
);

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [63:0] w_prod_s, w_prod_u;
    logic        w_div_zero;
    logic [31:0] w_abs_a, w_abs_b, w_qmag, w_rmag;
    logic [31:0] w_quo_s, w_rem_s, w_quo_u, w_rem_u;

    // Sign-extending to 64 bits lets one unsigned multiplier produce the signed product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    assign w_div_zero = (B == 32'd0);
    assign w_abs_a    = A[31] ? (32'd0 - A) : A;
    assign w_abs_b    = B[31] ? (32'd0 - B) : B;
    assign w_qmag     = w_div_zero ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_rmag     = w_div_zero ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_quo_s    = (A[31] ^ B[31]) ? (32'd0 - w_qmag) : w_qmag;
    assign w_rem_s    = A[31] ? (32'd0 - w_rmag) : w_rmag;
    assign w_quo_u    = w_div_zero ? 32'd0 : (A / B);
    assign w_rem_u    = w_div_zero ? 32'd0 : (A % B);

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        p_hi_d = p_hi_q;
        p_lo_d = p_lo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            // Every command is dropped while an operation is in flight.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d   = p_hi_q;
                lo_d   = p_lo_q;
                busy_d = 1'b0;
            end
        end else begin
            case (md_op)
                c_OP_MULT: begin
                    p_hi_d = w_prod_s[63:32];
                    p_lo_d = w_prod_s[31:0];
                    cnt_d  = c_MULT_CNT;
                    busy_d = 1'b1;
                end
                c_OP_MULTU: begin
                    p_hi_d = w_prod_u[63:32];
                    p_lo_d = w_prod_u[31:0];
                    cnt_d  = c_MULT_CNT;
                    busy_d = 1'b1;
                end
                c_OP_DIV: begin
                    p_hi_d = w_div_zero ? hi_q : w_rem_s;
                    p_lo_d = w_div_zero ? lo_q : w_quo_s;
                    cnt_d  = c_DIV_CNT;
                    busy_d = 1'b1;
                end
                c_OP_DIVU: begin
                    p_hi_d = w_div_zero ? hi_q : w_rem_u;
                    p_lo_d = w_div_zero ? lo_q : w_quo_u;
                    cnt_d  = c_DIV_CNT;
                    busy_d = 1'b1;
                end
                c_OP_MTHI: hi_d = A;
                c_OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            p_hi_q <= 32'd0;
            p_lo_q <= 32'd0;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign start = (md_op >= c_OP_MULT) && (md_op <= c_OP_DIVU);
    assign busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDO   = hilo_sel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Self-checking bench for mult_div_unit: directed cases plus
//            randomized traffic against a time-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk, reset, hilo_sel;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        start, busy;
    logic [31:0] HI, LO, MDO;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .A(A), .B(B),
        .hilo_sel(hilo_sel), .start(start), .busy(busy),
        .HI(HI), .LO(LO), .MDO(MDO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of an operation as {HI, LO}, straight from the arithmetic rules.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] hi,
                                                 input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {hi, lo};
        case (op)
            3'd1: p = 64'(sa * sb);
            3'd2: p = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) p = {a % b, a / b};
            default: ;
        endcase
        return p;
    endfunction

    // Model tracks absolute edge numbers: an issue at edge e completes at edge e+N.
    int          e_cnt  = 0;
    int          m_done = 0;
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    logic [63:0] m_res;

    always @(posedge clk) begin
        e_cnt = e_cnt + 1;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_busy = 1'b0; m_valid = 1'b1;
        end else if (m_busy) begin
            if (e_cnt == m_done) begin
                m_hi = m_phi; m_lo = m_plo; m_busy = 1'b0;
            end
        end else if (md_op >= 3'd1 && md_op <= 3'd4) begin
            m_res  = model_result(md_op, A, B, m_hi, m_lo);
            m_phi  = m_res[63:32];
            m_plo  = m_res[31:0];
            m_done = e_cnt + ((md_op <= 3'd2) ? MULT_N : DIV_N);
            m_busy = 1'b1;
        end else if (md_op == 3'd5) begin
            m_hi = A;
        end else if (md_op == 3'd6) begin
            m_lo = A;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_busy", {31'd0, busy}, {31'd0, m_busy});
            check("model_hi",   HI, m_hi);
            check("model_lo",   LO, m_lo);
            check("model_mdo",  MDO, hilo_sel ? m_hi : m_lo);
        end
        check("start", {31'd0, start}, {31'd0, (md_op >= 3'd1 && md_op <= 3'd4)});
    end

    // Called at posedge+1; issues on the next edge and returns once busy drops.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n_exp);
        int n;
        md_op = op; A = a; B = b;
        @(posedge clk); #1;
        md_op = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("busy_len", n, n_exp);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        md_op = op; A = a;
        @(posedge clk); #1;
        md_op = 3'd0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b1; md_op = 3'd0; A = 0; B = 0; hilo_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        check("rst_mdo", MDO, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);

        do_op(3'd1, 32'hFFFF_FFFD, 32'd5, MULT_N);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);
        #1 check("mult_mdo_lo", MDO, 32'hFFFF_FFF1);
        hilo_sel = 1'b1;
        #1 check("mult_mdo_hi", MDO, 32'hFFFF_FFFF);
        hilo_sel = 1'b0;
        @(posedge clk); #1;

        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, MULT_N);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, DIV_N);
        check("divu_hi", HI, 32'h0000_0001);
        check("divu_lo", LO, 32'h7FFF_FFFC);

        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, DIV_N);
        check("div_hi", HI, 32'hFFFF_FFFF);
        check("div_lo", LO, 32'hFFFF_FFFD);

        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
        check("divovf_hi", HI, 32'h0);
        check("divovf_lo", LO, 32'h8000_0000);

        move_to(3'd5, 32'h1234);
        move_to(3'd6, 32'h5678);
        check("mthi", HI, 32'h1234);
        check("mtlo", LO, 32'h5678);
        do_op(3'd3, 32'd77, 32'd0, DIV_N);
        check("div0_hi", HI, 32'h1234);
        check("div0_lo", LO, 32'h5678);

        // Commands presented during busy cycles 2 and 3 must be ignored.
        md_op = 3'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        n = 0;
        if (busy) n++;
        md_op = 3'd5; A = 32'hDEAD;
        @(posedge clk); #1;
        if (busy) n++;
        md_op = 3'd3; A = 32'd9; B = 32'd3;
        @(posedge clk); #1;
        md_op = 3'd0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("ignore_len", n, MULT_N);
        check("ignore_hi", HI, 32'h0);
        check("ignore_lo", LO, 32'd12);

        md_op = 3'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        md_op = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'h0);
        check("rstmid_hi", HI, 32'h0);
        check("rstmid_lo", LO, 32'h0);
        repeat (12) @(posedge clk);
        #1;
        check("rstmid_late_hi", HI, 32'h0);
        check("rstmid_late_lo", LO, 32'h0);
        do_op(3'd1, 32'd2, 32'd3, MULT_N);
        check("after_rst_lo", LO, 32'd6);
        check("after_rst_hi", HI, 32'd0);

        for (int i = 0; i < 800; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            md_op    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            A        = pick();
            B        = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            hilo_sel = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        reset = 1'b0; md_op = 3'd0;
        repeat (20) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
